// File: rtl/shared_mul_sched_pkg.sv
// Shared types and defaults for the shared-multiplier scheduler.
// The stage payload is sized by DEF_WIDTH, so WIDTH must not exceed it.
package shared_mul_pkg;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_LAT   = 2;
   localparam int unsigned PROD_W    = 2 * DEF_WIDTH;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_tag_e;

   typedef struct packed {
      logic             valid;
      req_tag_e         tag;
      logic [PROD_W-1:0] prod;
   } pipe_stage_t;

endpackage

// File: rtl/shared_mul_sched_if.sv
// Request/result handshakes of both requesters plus the busy flag.
interface shared_mul_sched_if
   import shared_mul_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
);
   logic               a_valid;
   logic               a_ready;
   logic [WIDTH-1:0]   a_op0;
   logic [WIDTH-1:0]   a_op1;
   logic               b_valid;
   logic               b_ready;
   logic [WIDTH-1:0]   b_op0;
   logic [WIDTH-1:0]   b_op1;
   logic               a_res_valid;
   logic               a_res_ready;
   logic [2*WIDTH-1:0] a_res;
   logic               b_res_valid;
   logic               b_res_ready;
   logic [2*WIDTH-1:0] b_res;
   logic               busy;

   modport master (
      output a_valid, a_op0, a_op1, b_valid, b_op0, b_op1, a_res_ready, b_res_ready,
      input  a_ready, b_ready, a_res_valid, a_res, b_res_valid, b_res, busy
   );

   modport slave (
      input  a_valid, a_op0, a_op1, b_valid, b_op0, b_op1, a_res_ready, b_res_ready,
      output a_ready, b_ready, a_res_valid, a_res, b_res_valid, b_res, busy
   );
endinterface

// File: rtl/shared_mul_sched_mul_pipe.sv
// Unsigned WIDTHxWIDTH multiplier with LAT-1 register stages; product formed at entry.
module mul_pipe
   import shared_mul_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned LAT   = DEF_LAT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_i,
   input  req_tag_e          tag_i,
   input  logic [WIDTH-1:0]  op0_i,
   input  logic [WIDTH-1:0]  op1_i,
   output pipe_stage_t       exit_o,
   output logic              busy_o
);
   localparam int unsigned PW = 2 * WIDTH;

   pipe_stage_t entry_c;

   always_comb begin
      entry_c.valid = valid_i;
      entry_c.tag   = tag_i;
      entry_c.prod  = PROD_W'(PW'(op0_i) * PW'(op1_i));
   end

   if (LAT == 1) begin : g_direct
      // Result register is the only stage: exit is the accept-cycle entry.
      assign exit_o = entry_c;
      assign busy_o = 1'b0;
   end else begin : g_regs
      pipe_stage_t stg_q [LAT-1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < int'(LAT) - 1; i++) stg_q[i] <= '0;
         end else begin
            stg_q[0] <= entry_c;
            for (int i = 1; i < int'(LAT) - 1; i++) stg_q[i] <= stg_q[i-1];
         end
      end

      always_comb begin
         busy_o = 1'b0;
         for (int i = 0; i < int'(LAT) - 1; i++) busy_o = busy_o | stg_q[i].valid;
      end

      assign exit_o = stg_q[LAT-2];
   end

endmodule

// File: rtl/shared_mul_sched.sv
// Round-robin scheduler sharing one pipelined multiplier between requesters A and B,
// with one outstanding operation and a holding result register per requester.
module shared_mul_sched
   import shared_mul_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned LAT   = DEF_LAT
) (
   input  logic              clk,
   input  logic              rst_n,
   shared_mul_sched_if.slave bus
);
   localparam int unsigned PW = 2 * WIDTH;

   req_tag_e          last_q, last_d;
   logic              out_a_q, out_a_d, out_b_q, out_b_d;
   logic              a_rv_q, a_rv_d, b_rv_q, b_rv_d;
   logic [PW-1:0]     a_res_q, a_res_d, b_res_q, b_res_d;

   logic              elig_a_c, elig_b_c, gnt_a_c, gnt_b_c;
   req_tag_e          tag_c;
   logic [WIDTH-1:0]  op0_c, op1_c;
   pipe_stage_t       exit_c;
   logic              pipe_busy_c;

   // Arbitration uses registered outstanding flags only, so a result consume
   // never feeds back into ready within the same cycle.
   always_comb begin
      elig_a_c = bus.a_valid && !out_a_q;
      elig_b_c = bus.b_valid && !out_b_q;
      gnt_a_c  = elig_a_c && (!elig_b_c || (last_q == REQ_B));
      gnt_b_c  = elig_b_c && (!elig_a_c || (last_q == REQ_A));
      tag_c    = gnt_b_c ? REQ_B : REQ_A;
      op0_c    = gnt_b_c ? bus.b_op0 : bus.a_op0;
      op1_c    = gnt_b_c ? bus.b_op1 : bus.a_op1;
   end

   mul_pipe #(.WIDTH(WIDTH), .LAT(LAT)) u_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (gnt_a_c || gnt_b_c),
      .tag_i   (tag_c),
      .op0_i   (op0_c),
      .op1_i   (op1_c),
      .exit_o  (exit_c),
      .busy_o  (pipe_busy_c)
   );

   always_comb begin
      last_d  = last_q;
      out_a_d = out_a_q;
      out_b_d = out_b_q;
      a_rv_d  = a_rv_q;
      b_rv_d  = b_rv_q;
      a_res_d = a_res_q;
      b_res_d = b_res_q;

      if (a_rv_q && bus.a_res_ready) begin
         a_rv_d  = 1'b0;
         out_a_d = 1'b0;
      end
      if (b_rv_q && bus.b_res_ready) begin
         b_rv_d  = 1'b0;
         out_b_d = 1'b0;
      end

      if (exit_c.valid && (exit_c.tag == REQ_A)) begin
         a_rv_d  = 1'b1;
         a_res_d = exit_c.prod[PW-1:0];
      end
      if (exit_c.valid && (exit_c.tag == REQ_B)) begin
         b_rv_d  = 1'b1;
         b_res_d = exit_c.prod[PW-1:0];
      end

      if (gnt_a_c) begin
         out_a_d = 1'b1;
         last_d  = REQ_A;
      end
      if (gnt_b_c) begin
         out_b_d = 1'b1;
         last_d  = REQ_B;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q  <= REQ_B;
         out_a_q <= 1'b0;
         out_b_q <= 1'b0;
         a_rv_q  <= 1'b0;
         b_rv_q  <= 1'b0;
         a_res_q <= '0;
         b_res_q <= '0;
      end else begin
         last_q  <= last_d;
         out_a_q <= out_a_d;
         out_b_q <= out_b_d;
         a_rv_q  <= a_rv_d;
         b_rv_q  <= b_rv_d;
         a_res_q <= a_res_d;
         b_res_q <= b_res_d;
      end
   end

   assign bus.a_ready     = gnt_a_c;
   assign bus.b_ready     = gnt_b_c;
   assign bus.a_res_valid = a_rv_q;
   assign bus.b_res_valid = b_rv_q;
   assign bus.a_res       = a_res_q;
   assign bus.b_res       = b_res_q;
   assign bus.busy        = pipe_busy_c || a_rv_q || b_rv_q;

endmodule

// File: tb/tb_shared_mul_sched.sv
// Randomized scoreboard bench for shared_mul_sched against a cycle-level request model.
module tb_shared_mul_sched;
   import shared_mul_pkg::*;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned LAT   = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   shared_mul_sched_if #(.WIDTH(WIDTH)) bus ();

   shared_mul_sched #(.WIDTH(WIDTH), .LAT(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Model state: index 0 is A, 1 is B; m_last 1 means B was granted last.
   bit          m_out [2];
   int          m_vis [2];
   bit          m_last;
   int          cyc;
   logic [15:0] q_a [$];
   logic [15:0] q_b [$];
   bit          acc_a, acc_b;
   bit          hold_a, hold_b;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] rand_op();
      case ($urandom_range(0, 7))
         0:       return 8'd0;
         1:       return 8'd255;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   // Request-level reference: eligibility, round-robin tie-break, result timing.
   initial begin : model
      bit ea, eb, ga, gb, rva, rvb;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            m_out[0] = 1'b0;
            m_out[1] = 1'b0;
            m_last   = 1'b1;
            acc_a    = 1'b0;
            acc_b    = 1'b0;
            q_a.delete();
            q_b.delete();
            check("rst_a_res_valid", 32'(bus.a_res_valid), 32'd0);
            check("rst_b_res_valid", 32'(bus.b_res_valid), 32'd0);
            check("rst_busy",        32'(bus.busy),        32'd0);
         end else begin
            ea  = bus.a_valid && !m_out[0];
            eb  = bus.b_valid && !m_out[1];
            ga  = ea && (!eb || m_last);
            gb  = eb && (!ea || !m_last);
            rva = m_out[0] && (cyc >= m_vis[0]);
            rvb = m_out[1] && (cyc >= m_vis[1]);
            check("a_ready",     32'(bus.a_ready),     32'(ga));
            check("b_ready",     32'(bus.b_ready),     32'(gb));
            check("a_res_valid", 32'(bus.a_res_valid), 32'(rva));
            check("b_res_valid", 32'(bus.b_res_valid), 32'(rvb));
            check("busy",        32'(bus.busy),        32'(m_out[0] || m_out[1]));
            acc_a = bus.a_valid && bus.a_ready;
            acc_b = bus.b_valid && bus.b_ready;
            if (rva && bus.a_res_ready) m_out[0] = 1'b0;
            if (rvb && bus.b_res_ready) m_out[1] = 1'b0;
            if (ga) begin
               m_out[0] = 1'b1;
               m_vis[0] = cyc + int'(LAT);
               m_last   = 1'b0;
               q_a.push_back(16'(int'(bus.a_op0) * int'(bus.a_op1)));
            end
            if (gb) begin
               m_out[1] = 1'b1;
               m_vis[1] = cyc + int'(LAT);
               m_last   = 1'b1;
               q_b.push_back(16'(int'(bus.b_op0) * int'(bus.b_op1)));
            end
         end
      end
   end

   // Result monitor: any presented result must match the head of its queue.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.a_res_valid) begin
               if (q_a.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL a_res_unexpected got=%0h exp=none t=%0t", bus.a_res, $time);
               end else begin
                  check("a_res", 32'(bus.a_res), 32'(q_a[0]));
                  if (bus.a_res_ready) void'(q_a.pop_front());
               end
            end
            if (bus.b_res_valid) begin
               if (q_b.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL b_res_unexpected got=%0h exp=none t=%0t", bus.b_res, $time);
               end else begin
                  check("b_res", 32'(bus.b_res), 32'(q_b[0]));
                  if (bus.b_res_ready) void'(q_b.pop_front());
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         if (acc_a && !hold_a) bus.a_valid = 1'b0;
         if (acc_b && !hold_b) bus.b_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      step();
   endtask

   task automatic rand_cycles(input int n, input int rdy_pct);
      for (int i = 0; i < n; i++) begin
         step();
         if (!(bus.a_valid && !acc_a)) begin
            bus.a_valid = ($urandom_range(0, 99) < 60);
            bus.a_op0   = rand_op();
            bus.a_op1   = rand_op();
         end else if ($urandom_range(0, 99) < 5) begin
            bus.a_valid = 1'b0;
         end
         if (!(bus.b_valid && !acc_b)) begin
            bus.b_valid = ($urandom_range(0, 99) < 60);
            bus.b_op0   = rand_op();
            bus.b_op1   = rand_op();
         end else if ($urandom_range(0, 99) < 5) begin
            bus.b_valid = 1'b0;
         end
         bus.a_res_ready = ($urandom_range(0, 99) < rdy_pct);
         bus.b_res_ready = ($urandom_range(0, 99) < rdy_pct);
      end
   endtask

   initial begin : driver
      bus.a_valid = 1'b0; bus.a_op0 = '0; bus.a_op1 = '0;
      bus.b_valid = 1'b0; bus.b_op0 = '0; bus.b_op1 = '0;
      bus.a_res_ready = 1'b0;
      bus.b_res_ready = 1'b0;
      hold_a = 1'b0;
      hold_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();

      // Single op from reset.
      bus.a_valid = 1'b1; bus.a_op0 = 8'd12; bus.a_op1 = 8'd13;
      bus.a_res_ready = 1'b1; bus.b_res_ready = 1'b1;
      run(6);

      // Simultaneous requests after reset: A wins the first tie.
      do_reset();
      bus.a_valid = 1'b1; bus.a_op0 = 8'd3; bus.a_op1 = 8'd5;
      bus.b_valid = 1'b1; bus.b_op0 = 8'd7; bus.b_op1 = 8'd9;
      run(6);

      // Backpressure on A while B streams.
      hold_a = 1'b1;
      bus.a_res_ready = 1'b0;
      bus.a_valid = 1'b1; bus.a_op0 = 8'd17; bus.a_op1 = 8'd19;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!(bus.b_valid && !acc_b)) begin
            bus.b_valid = 1'b1;
            bus.b_op0   = rand_op();
            bus.b_op1   = rand_op();
         end
      end
      // Consume while A stays valid: next grant only a cycle later.
      bus.b_valid = 1'b0;
      bus.a_res_ready = 1'b1;
      run(8);
      hold_a = 1'b0;
      run(5);

      // Operand extremes.
      bus.a_valid = 1'b1; bus.a_op0 = 8'd255; bus.a_op1 = 8'd255;
      bus.b_valid = 1'b1; bus.b_op0 = 8'd0;   bus.b_op1 = 8'd255;
      run(6);

      rand_cycles(1500, 70);
      rand_cycles(500, 20);

      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      bus.a_res_ready = 1'b1; bus.b_res_ready = 1'b1;
      run(8);

      // Reset one cycle after an A accept discards the operation.
      bus.a_valid = 1'b1; bus.a_op0 = 8'd200; bus.a_op1 = 8'd100;
      run(1);
      check("busy_before_rst", 32'(bus.busy), 32'd1);
      #1;
      rst_n = 1'b0;
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      #1;
      check("async_rst_busy",        32'(bus.busy),        32'd0);
      check("async_rst_a_res_valid", 32'(bus.a_res_valid), 32'd0);
      check("async_rst_b_res_valid", 32'(bus.b_res_valid), 32'd0);
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      step();
      bus.a_valid = 1'b1; bus.a_op0 = 8'd3; bus.a_op1 = 8'd5;
      bus.b_valid = 1'b1; bus.b_op0 = 8'd7; bus.b_op1 = 8'd9;
      run(8);

      bus.a_valid = 1'b0; bus.b_valid = 1'b0;
      run(6);
      check("a_queue_drained", 32'(q_a.size()), 32'd0);
      check("b_queue_drained", 32'(q_b.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shared_mul_sched.md
Name: shared_mul_sched

Overview:
- Schedules one shared pipelined unsigned multiplier between two requesters, A and B. This is the sequential counterpart of muxed-operand resource sharing: one physical multiplier, with operand selection by grant.
- Round-robin arbitration, valid/ready handshakes on both request and result sides.
- At most one outstanding operation per requester. Results can therefore never collide or be dropped.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH.
- LAT, 2, cycles from request-accept edge to result-valid; must be >= 1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  requester A operation valid
- a_ready  out  1  requester A operation accepted this cycle
- a_op0  in  WIDTH  requester A multiplicand
- a_op1  in  WIDTH  requester A multiplier
- b_valid  in  1  requester B operation valid
- b_ready  out  1  requester B operation accepted this cycle
- b_op0  in  WIDTH  requester B multiplicand
- b_op1  in  WIDTH  requester B multiplier
- a_res_valid  out  1  result for A available
- a_res_ready  in  1  A consumes result
- a_res  out  2*WIDTH  A product
- b_res_valid  out  1  result for B available
- b_res_ready  in  1  B consumes result
- b_res  out  2*WIDTH  B product
- busy  out  1  any operation in pipe or any result register full

Behaviour:
- Reset (rst_n low, asynchronous):
  - all pipe valids, outstanding flags and res_valids clear to 0; res data clears to 0.
  - last_grant is set to B, so A wins the first tie.
  - In-flight work is discarded; a reset mid-operation yields no result.
- Eligibility: elig_X = X_valid && !outstanding_X.
- Grant (combinational):
  - only one eligible → that one is granted;
  - both eligible → the one not equal to last_grant is granted;
  - none eligible → no grant.
  - a_ready/b_ready equal the grant bits; at most one is high per cycle.
- Issue: on the clock edge where X_valid && X_ready:
  - operands and tag X enter the pipe;
  - outstanding_X sets to 1 and last_grant becomes X.
- Pipe:
  - LAT-1 register stages, each carrying valid, tag and product; the product is computed at entry.
  - The result register is the final stage.
  - LAT=1: the product is written directly into the result register at the accept edge.
- Result register:
  - loaded when the pipe-exit valid is set; X_res_valid=1 and X_res = full unsigned product (no truncation).
  - holds until X_res_valid && X_res_ready at an edge, then X_res_valid clears and outstanding_X clears on that same edge.
- Latency: accept at edge t → X_res_valid high immediately after edge t+LAT-1, i.e. visible in cycle t+LAT. Example with LAT=2: accept at edge 0 → visible in cycle 2.
- No combinational path from X_res_ready to X_ready. With a same-cycle result-consume and new X_valid, X is eligible only in the following cycle.
- Throughput:
  - one requester alone: 1 op per LAT+1 cycles when the result is consumed immediately;
  - both active: grants alternate A,B,A,B.
- Backpressure: a stalled consumer blocks only its own requester; the other continues at full rate.
- Operands must be held stable while X_valid is high and X_ready is low. Dropping X_valid before accept is permitted and has no effect.
- busy = OR of pipe valids, a_res_valid and b_res_valid.

Decomposition:
- Shared package shared_mul_pkg:
  - requester tag enum {REQ_A, REQ_B};
  - default WIDTH/LAT constants;
  - pipe stage struct {valid, tag, prod}.
- One sub-module, mul_pipe:
  - WIDTH×WIDTH unsigned multiply with LAT-1 register stages, valid and tag passthrough;
  - asynchronous active-low clear of valids.
- The arbiter, outstanding flags and result registers stay in shared_mul_sched.

Test Plan:
- Reset + single op:
  - after reset, A requests 8'd12×8'd13, a_res_ready=1;
  - expect a_ready high in cycle 0, a_res_valid high in cycle 2 (LAT=2) with a_res=16'd156, busy low one cycle after consume.
- Simultaneous requests after reset, A=3×5, B=7×9:
  - A granted in cycle 0, B granted in cycle 1;
  - a_res=15 in cycle 2, b_res=63 in cycle 3.
- Backpressure isolation: hold a_res_ready=0 with A continuously valid.
  - A gets exactly one grant; a_res holds its value and a_ready stays 0.
  - B keeps being granted in every eligible cycle with correct products.
- Max operands: 255×255 → res=16'hFE01; 0×255 → 0.
- Same-cycle consume + new request:
  - A result consumed at edge k while a_valid is high;
  - a_ready stays low in cycle k and goes high in cycle k+1.
- Reset mid-operation: assert rst_n low one cycle after an A accept.
  - all res_valids and busy are 0 immediately (asynchronous);
  - after release, no stale result appears, and A wins the next tie.
